// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined shift unit: op encodings, fill modes,
// default geometry and the bit-reversal helper used to turn left shifts into right shifts.
package shift_pkg;

  localparam int SHIFT_WIDTH = 16;
  localparam int SHIFT_AMT_W = $clog2(SHIFT_WIDTH);
  localparam int SHIFT_TAG_W = 3;

  typedef enum logic [2:0] {
    OP_SLL = 3'b000,
    OP_SRL = 3'b001,
    OP_SRA = 3'b010,
    OP_ROL = 3'b011,
    OP_ROR = 3'b100
  } shift_op_e;

  typedef enum logic [1:0] {
    FILL_ZERO = 2'b00,
    FILL_SIGN = 2'b01,
    FILL_ROT  = 2'b10
  } fill_mode_e;

  function automatic logic op_legal(input logic [2:0] op);
    return op <= OP_ROR;
  endfunction

  function automatic logic op_is_left(input logic [2:0] op);
    return (op == OP_SLL) || (op == OP_ROL);
  endfunction

  function automatic fill_mode_e op_mode(input logic [2:0] op);
    fill_mode_e m;
    case (op)
      OP_SRA:         m = FILL_SIGN;
      OP_ROL, OP_ROR: m = FILL_ROT;
      default:        m = FILL_ZERO;
    endcase
    return m;
  endfunction

  function automatic logic [SHIFT_WIDTH-1:0] bit_reverse(input logic [SHIFT_WIDTH-1:0] d);
    logic [SHIFT_WIDTH-1:0] r;
    for (int i = 0; i < SHIFT_WIDTH; i++) r[i] = d[SHIFT_WIDTH-1-i];
    return r;
  endfunction

endpackage

// File: rtl/shift_row_stage.sv
// One row of the logarithmic shifter: an optional right shift by DIST whose
// vacated upper bits are filled with zero, the sign bit, or the bits shifted out.
module shift_row_stage
  import shift_pkg::*;
#(
  parameter int WIDTH = SHIFT_WIDTH,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             en_i,
  input  fill_mode_e       mode_i,
  input  logic             sign_i,
  output logic [WIDTH-1:0] data_o
);

  logic [DIST-1:0] fill;

  always_comb begin
    fill = '0;
    case (mode_i)
      FILL_SIGN: fill = {DIST{sign_i}};
      FILL_ROT:  fill = data_i[DIST-1:0];
      default:   fill = '0;
    endcase
    data_o = en_i ? {fill, data_i[WIDTH-1:DIST]} : data_i;
  end

endmodule

// File: rtl/shift_exec_pipe.sv
// Two-stage execute shift unit: rows 1,2 feed S1, rows 4,8 feed S2 (the output register).
// Left ops run reversed through the right-only shifter and are un-reversed after row 8.
module shift_exec_pipe
  import shift_pkg::*;
#(
  parameter int WIDTH = SHIFT_WIDTH,
  parameter int AMT_W = $clog2(WIDTH),
  parameter int TAG_W = SHIFT_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amnt,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_zero,
  output logic             out_err
);

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // in_ready is a function of pipeline occupancy, out_ready and flush only.
  logic s1_v_q, s1_v_d, s2_v_q, s2_v_d;
  logic s1_adv, s2_adv, accept, s1_load, s2_load;

  logic [WIDTH-1:0] s1_data_q, s1_data_d;
  logic [1:0]       s1_amt_q, s1_amt_d;
  logic [2:0]       s1_op_q, s1_op_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
  logic             s1_rev_q, s1_rev_d, s1_sign_q, s1_sign_d, s1_err_q, s1_err_d;

  logic [WIDTH-1:0] s2_data_q, s2_data_d;
  logic [TAG_W-1:0] s2_tag_q;
  logic             s2_zero_q, s2_err_q;

  logic [WIDTH-1:0] s1_entry, row1_out, row2_out, row4_out, row8_out;
  logic             in_legal;

  assign s2_adv   = !s2_v_q || out_ready;
  assign s1_adv   = !s1_v_q || s2_adv;
  assign in_ready = s1_adv && !flush;
  assign accept   = in_valid && in_ready;
  assign s1_load  = accept;
  assign s2_load  = s2_adv && s1_v_q && !flush;

  assign s1_v_d = flush ? 1'b0 : (s1_adv ? accept : s1_v_q);
  assign s2_v_d = flush ? 1'b0 : (s2_adv ? s1_v_q : s2_v_q);

  assign in_legal = op_legal(in_op);
  assign s1_entry = (in_legal && op_is_left(in_op)) ? bit_reverse(in_data) : in_data;

  shift_row_stage #(.WIDTH(WIDTH), .DIST(1)) u_row1 (
    .data_i (s1_entry),
    .en_i   (in_legal && in_amnt[0]),
    .mode_i (op_mode(in_op)),
    .sign_i (in_data[WIDTH-1]),
    .data_o (row1_out)
  );

  shift_row_stage #(.WIDTH(WIDTH), .DIST(2)) u_row2 (
    .data_i (row1_out),
    .en_i   (in_legal && in_amnt[1]),
    .mode_i (op_mode(in_op)),
    .sign_i (in_data[WIDTH-1]),
    .data_o (row2_out)
  );

  // Illegal ops carry a zero remaining amount so S2 passes the operand through.
  always_comb begin
    s1_data_d = row2_out;
    s1_amt_d  = in_legal ? in_amnt[3:2] : 2'b00;
    s1_op_d   = in_op;
    s1_tag_d  = in_tag;
    s1_rev_d  = in_legal && op_is_left(in_op);
    s1_sign_d = in_data[WIDTH-1];
    s1_err_d  = !in_legal;
  end

  shift_row_stage #(.WIDTH(WIDTH), .DIST(4)) u_row4 (
    .data_i (s1_data_q),
    .en_i   (s1_amt_q[0]),
    .mode_i (op_mode(s1_op_q)),
    .sign_i (s1_sign_q),
    .data_o (row4_out)
  );

  shift_row_stage #(.WIDTH(WIDTH), .DIST(8)) u_row8 (
    .data_i (row4_out),
    .en_i   (s1_amt_q[1]),
    .mode_i (op_mode(s1_op_q)),
    .sign_i (s1_sign_q),
    .data_o (row8_out)
  );

  assign s2_data_d = s1_rev_q ? bit_reverse(row8_out) : row8_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
    end else begin
      s1_v_q <= s1_v_d;
      s2_v_q <= s2_v_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_data_q <= '0;
      s1_amt_q  <= '0;
      s1_op_q   <= '0;
      s1_tag_q  <= '0;
      s1_rev_q  <= 1'b0;
      s1_sign_q <= 1'b0;
      s1_err_q  <= 1'b0;
    end else if (s1_load) begin
      s1_data_q <= s1_data_d;
      s1_amt_q  <= s1_amt_d;
      s1_op_q   <= s1_op_d;
      s1_tag_q  <= s1_tag_d;
      s1_rev_q  <= s1_rev_d;
      s1_sign_q <= s1_sign_d;
      s1_err_q  <= s1_err_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_data_q <= '0;
      s2_tag_q  <= '0;
      s2_zero_q <= 1'b0;
      s2_err_q  <= 1'b0;
    end else if (s2_load) begin
      s2_data_q <= s2_data_d;
      s2_tag_q  <= s1_tag_q;
      s2_zero_q <= (s2_data_d == '0);
      s2_err_q  <= s1_err_q;
    end
  end

  assign out_valid = s2_v_q;
  assign out_data  = s2_data_q;
  assign out_tag   = s2_tag_q;
  assign out_zero  = s2_zero_q;
  assign out_err   = s2_err_q;

endmodule
